// File: rtl/cnn_acc_ci_pkg.sv
// Shared core defaults for the CNN channel accumulator (CI, AK_BW, B_BW, O_F_BW)
// plus a small width helper used for the channel counter.
package cnn_acc_ci_pkg;

   localparam int CNN_CI     = 3;
   localparam int CNN_AK_BW  = 20;
   localparam int CNN_B_BW   = 8;
   localparam int CNN_O_F_BW = 8;

   // A counter for a single channel still needs one (constant) bit.
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnn_acc_ci_act.sv
// cnn_act: bias add (stage 2) followed by registered activation/saturation.
// CNN_ACC_RELU_EN selects ReLU with unsigned saturation; otherwise signed saturation.
module cnn_act
   import cnn_acc_ci_pkg::*;
#(
   parameter int ACI_BW = 22,
   parameter int B_BW   = CNN_B_BW,
   parameter int O_F_BW = CNN_O_F_BW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_soft_reset,
   input  logic              i_valid,
   input  logic [ACI_BW-1:0] i_acc,
   input  logic [B_BW-1:0]   i_bias,
   output logic              o_valid,
   output logic [O_F_BW-1:0] o_fmap
);

   // One spare bit so the saturation bounds are representable whatever the widths.
   localparam int CMP_W = ((ACI_BW > O_F_BW) ? ACI_BW : O_F_BW) + 1;

   logic [ACI_BW-1:0]       bias_ext;
   logic [ACI_BW-1:0]       sum_d, sum_q;
   logic                    sum_vld_d, sum_vld_q;
   logic signed [CMP_W-1:0] sum_ext;
   logic [O_F_BW-1:0]       sat_val;
   logic [O_F_BW-1:0]       fmap_d, fmap_q;
   logic                    vld_d, vld_q;

   assign bias_ext = {{(ACI_BW-B_BW){i_bias[B_BW-1]}}, i_bias};
   assign sum_ext  = {{(CMP_W-ACI_BW){sum_q[ACI_BW-1]}}, sum_q};

`ifdef CNN_ACC_RELU_EN
   localparam logic signed [CMP_W-1:0] SAT_HI = {{(CMP_W-O_F_BW){1'b0}}, {O_F_BW{1'b1}}};

   always_comb begin
      sat_val = sum_ext[O_F_BW-1:0];
      if (sum_ext[CMP_W-1]) begin
         sat_val = '0;
      end else if (sum_ext > SAT_HI) begin
         sat_val = '1;
      end
   end
`else
   localparam logic signed [CMP_W-1:0] SAT_HI = {{(CMP_W-O_F_BW+1){1'b0}}, {(O_F_BW-1){1'b1}}};
   localparam logic signed [CMP_W-1:0] SAT_LO = ~SAT_HI;

   always_comb begin
      sat_val = sum_ext[O_F_BW-1:0];
      if (sum_ext > SAT_HI) begin
         sat_val = SAT_HI[O_F_BW-1:0];
      end else if (sum_ext < SAT_LO) begin
         sat_val = SAT_LO[O_F_BW-1:0];
      end
   end
`endif

   always_comb begin
      sum_vld_d = i_valid & ~i_soft_reset;
      sum_d     = sum_q;
      vld_d     = sum_vld_q & ~i_soft_reset;
      fmap_d    = fmap_q;
      if (i_soft_reset) begin
         sum_d  = '0;
         fmap_d = '0;
      end else begin
         if (i_valid) begin
            sum_d = i_acc + bias_ext;
         end
         if (sum_vld_q) begin
            fmap_d = sat_val;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q     <= '0;
         sum_vld_q <= 1'b0;
         fmap_q    <= '0;
         vld_q     <= 1'b0;
      end else begin
         sum_q     <= sum_d;
         sum_vld_q <= sum_vld_d;
         fmap_q    <= fmap_d;
         vld_q     <= vld_d;
      end
   end

   assign o_valid = vld_q;
   assign o_fmap  = fmap_q;

endmodule

// File: rtl/cnn_acc_ci.sv
// Sums CI per-channel kernel sums into one output pixel, then adds bias and activates.
// Activation mode chosen by macro CNN_ACC_RELU_EN (see cnn_act).
module cnn_acc_ci
   import cnn_acc_ci_pkg::*;
#(
   parameter int CI     = CNN_CI,
   parameter int AK_BW  = CNN_AK_BW,
   parameter int B_BW   = CNN_B_BW,
   parameter int O_F_BW = CNN_O_F_BW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_soft_reset,
   input  logic              i_in_valid,
   input  logic [AK_BW-1:0]  i_in_kernel_acc,
   input  logic [B_BW-1:0]   i_bias,
   output logic              o_ot_valid,
   output logic [O_F_BW-1:0] o_ot_fmap,
   output logic              o_busy
);

   localparam int ACI_BW = AK_BW + $clog2(CI) + 1;
   localparam int CNT_W  = cnt_bits(CI);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CI - 1);

   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic [ACI_BW-1:0] acc_d, acc_q;
   logic              done_d, done_q;
   logic [B_BW-1:0]   bias_d, bias_q;
   logic [ACI_BW-1:0] in_ext;
   logic              last_ch;

   assign in_ext  = {{(ACI_BW-AK_BW){1'b0}}, i_in_kernel_acc};
   assign last_ch = (cnt_q == CNT_LAST);

   // acc_q holds the complete channel sum in the cycle that done_q is high.
   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      done_d = 1'b0;
      bias_d = bias_q;
      if (i_soft_reset) begin
         cnt_d  = '0;
         acc_d  = '0;
         bias_d = '0;
      end else if (i_in_valid) begin
         cnt_d  = last_ch ? '0 : cnt_q + CNT_W'(1);
         acc_d  = (cnt_q == '0) ? in_ext : acc_q + in_ext;
         done_d = last_ch;
         if (last_ch) begin
            bias_d = i_bias;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         done_q <= 1'b0;
         bias_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         done_q <= done_d;
         bias_q <= bias_d;
      end
   end

   assign o_busy = (cnt_q != '0);

   cnn_act #(
      .ACI_BW (ACI_BW),
      .B_BW   (B_BW),
      .O_F_BW (O_F_BW)
   ) u_act (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_soft_reset (i_soft_reset),
      .i_valid      (done_q),
      .i_acc        (acc_q),
      .i_bias       (bias_q),
      .o_valid      (o_ot_valid),
      .o_fmap       (o_ot_fmap)
   );

endmodule

// File: tb/tb_cnn_acc_ci.sv
// Self-checking bench for cnn_acc_ci (CI=3, AK_BW=20, B_BW=8, O_F_BW=8).
// Expected pixels and their arrival cycles are queued as stimulus is driven.
module tb_cnn_acc_ci;

   localparam int CI     = 3;
   localparam int AK_BW  = 20;
   localparam int B_BW   = 8;
   localparam int O_F_BW = 8;

   logic              clk;
   logic              reset_n;
   logic              i_soft_reset;
   logic              i_in_valid;
   logic [AK_BW-1:0]  i_in_kernel_acc;
   logic [B_BW-1:0]   i_bias;
   logic              o_ot_valid;
   logic [O_F_BW-1:0] o_ot_fmap;
   logic              o_busy;

   cnn_acc_ci #(
      .CI     (CI),
      .AK_BW  (AK_BW),
      .B_BW   (B_BW),
      .O_F_BW (O_F_BW)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_soft_reset    (i_soft_reset),
      .i_in_valid      (i_in_valid),
      .i_in_kernel_acc (i_in_kernel_acc),
      .i_bias          (i_bias),
      .o_ot_valid      (o_ot_valid),
      .o_ot_fmap       (o_ot_fmap),
      .o_busy          (o_busy)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [O_F_BW-1:0] exp_q[$];
   int                exp_cyc_q[$];
   logic [O_F_BW-1:0] last_exp = '0;
   int                grp_cnt  = 0;
   int                grp_sum  = 0;
   int                n_checks = 0;
   int                n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [O_F_BW-1:0] model(input int s);
      logic [31:0] sv;
      sv = s;
`ifdef CNN_ACC_RELU_EN
      if (s < 0) return 8'd0;
      if (s > 255) return 8'd255;
`else
      if (s > 127) return 8'd127;
      if (s < -128) return 8'h80;
`endif
      return sv[7:0];
   endfunction

   // driver tasks: all start and end at posedge+1
   task automatic drive_in(input logic [AK_BW-1:0] v, input int b);
      i_in_valid      = 1'b1;
      i_in_kernel_acc = v;
      if (grp_cnt == CI - 1) i_bias = 8'(b);
      else i_bias = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      i_in_valid      = 1'b0;
      i_in_kernel_acc = 20'($urandom_range(0, 20'hFFFFF));
      i_bias          = 8'($urandom_range(0, 255));
      grp_sum += int'(v);
      grp_cnt++;
      if (grp_cnt == CI) begin
         exp_q.push_back(model(grp_sum + b));
         exp_cyc_q.push_back(cyc + 2);
         grp_cnt = 0;
         grp_sum = 0;
      end
      check("busy", o_busy, grp_cnt != 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      check("drain", exp_q.size(), 0);
      idle(2);
   endtask

   task automatic soft_reset(input logic with_valid);
      i_soft_reset    = 1'b1;
      i_in_valid      = with_valid;
      i_in_kernel_acc = 20'd99;
      @(posedge clk); #1;
      i_soft_reset = 1'b0;
      i_in_valid   = 1'b0;
      grp_cnt = 0;
      grp_sum = 0;
      exp_q.delete();
      exp_cyc_q.delete();
      last_exp = '0;
      check("soft_busy", o_busy, 0);
      check("soft_valid", o_ot_valid, 0);
      check("soft_fmap", o_ot_fmap, 0);
   endtask

   task automatic async_reset();
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check("arst_valid", o_ot_valid, 0);
      check("arst_fmap", o_ot_fmap, 0);
      check("arst_busy", o_busy, 0);
      grp_cnt = 0;
      grp_sum = 0;
      exp_q.delete();
      exp_cyc_q.delete();
      last_exp = '0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // output monitor on the falling edge
   always @(negedge clk) begin
      logic [O_F_BW-1:0] e;
      int                ec;
      if (reset_n) begin
         if (o_ot_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               check("fmap", o_ot_fmap, e);
               check("latency", cyc, ec);
               last_exp = e;
            end
         end else begin
            check("hold", o_ot_fmap, last_exp);
         end
      end
   end

   initial begin
      reset_n         = 1'b0;
      i_soft_reset    = 1'b0;
      i_in_valid      = 1'b0;
      i_in_kernel_acc = '0;
      i_bias          = '0;
      #2;
      check("rst_valid", o_ot_valid, 0);
      check("rst_fmap", o_ot_fmap, 0);
      check("rst_busy", o_busy, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // basic group straight out of reset
      drive_in(20'd10, -5); drive_in(20'd20, -5); drive_in(20'd30, -5);
      drain();

      // negative sum and positive saturation
      drive_in(20'd0, -7); drive_in(20'd0, -7); drive_in(20'd0, -7);
      drain();
      drive_in(20'd100, 0); drive_in(20'd100, 0); drive_in(20'd100, 0);
      drain();

      // back-to-back groups
      for (int i = 1; i <= 6; i++) drive_in(20'(i), 0);
      drain();

      // soft reset drops a partial group; gapped inputs afterwards
      drive_in(20'd50, 0); drive_in(20'd50, 0);
      soft_reset(1'b0);
      drive_in(20'd1, 0); idle(2); drive_in(20'd2, 0); idle(1); drive_in(20'd3, 0);
      drain();

      // soft reset wins over a same-cycle input
      drive_in(20'd7, 0);
      soft_reset(1'b1);
      drive_in(20'd5, 0); drive_in(20'd5, 0); drive_in(20'd5, 0);
      drain();

      // asynchronous reset mid-group
      drive_in(20'd9, 0);
      async_reset();
      drive_in(20'd4, 1); drive_in(20'd4, 1); drive_in(20'd4, 1);
      drain();

      // accumulator extremes and bias range limits
      for (int i = 0; i < CI; i++) drive_in(20'hFFFFF, 127);
      for (int i = 0; i < CI; i++) drive_in(20'd0, -128);
      for (int i = 0; i < CI; i++) drive_in(20'd40, -128);
      drain();

      // random groups with random gaps
      for (int g = 0; g < 15; g++) begin
         int b;
         b = int'($urandom_range(0, 255)) - 128;
         for (int c = 0; c < CI; c++) begin
            logic [AK_BW-1:0] v;
            if ($urandom_range(0, 3) == 0) v = 20'($urandom_range(0, 20'hFFFFF));
            else v = 20'($urandom_range(0, 60));
            drive_in(v, b);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         end
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
